// File: rtl/systolic_feeder_pkg.sv
// Shared types and helpers for the systolic feeder: FSM state enum, default
// sizes, and the diagonal-skew index function used by every lane.
package systolic_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned N_DEF      = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] idx;
  } skew_t;

  // Lane `lane` carries element (t - lane) of its vector while 0 <= t-lane < n.
  function automatic skew_t skew_idx(input logic [31:0] t,
                                     input logic [31:0] lane,
                                     input logic [31:0] n);
    skew_t r;
    r.valid = (t >= lane) && ((t - lane) < n);
    r.idx   = r.valid ? (t - lane) : '0;
    return r;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One skewed output lane: registers element (t - LANE) of its stored vector,
// or zero outside the diagonal window or when not enabled.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned T_W    = 3,
  parameter int unsigned LANE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [T_W-1:0]        i_t,
  input  logic [N*DATA_W-1:0]   i_vec,
  output logic [DATA_W-1:0]     o_lane
);

  logic [31:0]       w_t32;
  skew_t             w_sk;
  logic [DATA_W-1:0] w_elem;

  assign w_t32 = {{(32-T_W){1'b0}}, i_t};
  assign w_sk  = skew_idx(w_t32, 32'(LANE), 32'(N));

  always_comb begin
    w_elem = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_sk.valid && (w_sk.idx == k)) w_elem = i_vec[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       o_lane <= '0;
    else if (i_en) o_lane <= w_elem;
    else           o_lane <= '0;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN output-stationary systolic MAC array: buffers A and
// B, then clears the array and streams skewed A rows / B columns.
// Build option: SYSTOLIC_FEEDER_BCOL_EN makes B loads column-wise.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned N         = N_DEF,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic                   ld_mat,
  input  logic [$clog2(N)-1:0]   ld_row,
  input  logic [N*DATA_W-1:0]    ld_data,
  input  logic                   go,
  output logic                   busy,
  output logic                   arr_clr,
  output logic                   out_valid,
  output logic [N*DATA_W-1:0]    a_lanes,
  output logic [N*DATA_W-1:0]    b_lanes,
  output logic                   done
);

  localparam int unsigned T_W   = $clog2(2*N);
  localparam int unsigned D_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [T_W-1:0] T_END = T_W'(2*N-1);
  localparam logic [D_W-1:0] D_END = D_W'(DRAIN_CYC-1);

  state_t                       r_state;
  logic [T_W-1:0]               r_t;
  logic [D_W-1:0]               r_dcnt;
  logic                         r_ld_ready;
  logic                         r_busy;
  logic                         r_arr_clr;
  logic                         r_out_valid;
  logic                         r_done;
  logic [1:0][N-1:0]            r_loaded;
  logic [N-1:0][N*DATA_W-1:0]   r_a;
  logic [N-1:0][N*DATA_W-1:0]   r_b;
  logic [N-1:0][N*DATA_W-1:0]   w_bcol;
  logic                         w_ld_fire;
  logic                         w_lane_en;

  assign w_ld_fire = ld_valid && r_ld_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_loaded <= '0;
    end else if (r_state == FIN) begin
      r_loaded <= '0;
    end else if (w_ld_fire) begin
      r_loaded[ld_mat][ld_row] <= 1'b1;
      if (!ld_mat) r_a[ld_row] <= ld_data;
`ifdef SYSTOLIC_FEEDER_BCOL_EN
      else begin
        for (int unsigned k = 0; k < N; k++)
          r_b[k][ld_row*DATA_W +: DATA_W] <= ld_data[k*DATA_W +: DATA_W];
      end
`else
      else r_b[ld_row] <= ld_data;
`endif
    end
  end

  // r_t is the stream index the lanes will present after the next edge, so the
  // lane registers are loaded one cycle ahead from CLEAR onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_t         <= '0;
      r_dcnt      <= '0;
      r_ld_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_arr_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_arr_clr <= 1'b0;
      r_done    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (go && (&r_loaded)) begin
            r_state    <= CLEAR;
            r_ld_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_arr_clr  <= 1'b1;
            r_t        <= '0;
          end
        end
        CLEAR: begin
          r_state     <= STREAM;
          r_out_valid <= 1'b1;
          r_t         <= r_t + T_W'(1);
        end
        STREAM: begin
          if (r_t == T_END) begin
            r_state <= DRAIN;
            r_dcnt  <= '0;
          end else begin
            r_t <= r_t + T_W'(1);
          end
        end
        DRAIN: begin
          if (r_dcnt == D_END) begin
            r_state     <= FIN;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + D_W'(1);
          end
        end
        FIN: begin
          r_state    <= IDLE;
          r_ld_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_lane_en = (r_state == CLEAR) || ((r_state == STREAM) && (r_t != T_END));

  for (genvar j = 0; j < N; j++) begin : g_bcol
    for (genvar k = 0; k < N; k++) begin : g_elem
      assign w_bcol[j][k*DATA_W +: DATA_W] = r_b[k][j*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    systolic_skew_lane #(.DATA_W(DATA_W), .N(N), .T_W(T_W), .LANE(g)) u_a_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_lane_en),
      .i_t    (r_t),
      .i_vec  (r_a[g]),
      .o_lane (a_lanes[g*DATA_W +: DATA_W])
    );
    systolic_skew_lane #(.DATA_W(DATA_W), .N(N), .T_W(T_W), .LANE(g)) u_b_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_lane_en),
      .i_t    (r_t),
      .i_vec  (w_bcol[g]),
      .o_lane (b_lanes[g*DATA_W +: DATA_W])
    );
  end

  assign ld_ready  = r_ld_ready;
  assign busy      = r_busy;
  assign arr_clr   = r_arr_clr;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: timeline model of the feeder plus directed
// scenarios (partial load, busy load, mid-stream reset, full matrix product).
module tb_systolic_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned DC = 4;
  localparam int unsigned LW = N*DW;
  localparam int unsigned RW = $clog2(N);
  localparam int DONE_K = 2 + (2*N-1) + DC;

  logic          clk, rst, ld_valid, ld_ready, ld_mat, go;
  logic          busy, arr_clr, out_valid, done;
  logic [RW-1:0] ld_row;
  logic [LW-1:0] ld_data, a_lanes, b_lanes;

  systolic_feeder #(.DATA_W(DW), .N(N), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_mat(ld_mat), .ld_row(ld_row), .ld_data(ld_data), .go(go),
    .busy(busy), .arr_clr(arr_clr), .out_valid(out_valid),
    .a_lanes(a_lanes), .b_lanes(b_lanes), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: matrices, loaded flags, and m_k = cycles since go was accepted (0 = idle).
  logic [DW-1:0] mA [N][N];
  logic [DW-1:0] mB [N][N];
  bit            mL [2][N];
  int            m_k = 0;
  bit            m_live = 0;

  always @(posedge clk) begin
    bit all_l;
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin mA[i][j] = '0; mB[i][j] = '0; end
      for (int i = 0; i < N; i++) begin mL[0][i] = 0; mL[1][i] = 0; end
      m_k = 0;
      m_live = 1;
    end else if (m_live) begin
      if (m_k == 0) begin
        all_l = 1;
        for (int i = 0; i < N; i++) all_l = all_l & mL[0][i] & mL[1][i];
        if (go && all_l) m_k = 1;
        if (ld_valid) begin
          mL[ld_mat][ld_row] = 1;
          for (int k = 0; k < N; k++) begin
            if (!ld_mat) mA[ld_row][k] = ld_data[k*DW +: DW];
`ifdef SYSTOLIC_FEEDER_BCOL_EN
            else mB[k][ld_row] = ld_data[k*DW +: DW];
`else
            else mB[ld_row][k] = ld_data[k*DW +: DW];
`endif
          end
        end
      end else if (m_k == DONE_K) begin
        m_k = 0;
      end else begin
        m_k++;
        if (m_k == DONE_K)
          for (int i = 0; i < N; i++) begin mL[0][i] = 0; mL[1][i] = 0; end
      end
    end
  end

  function automatic logic [LW-1:0] exp_lanes(input bit is_b, input int k);
    logic [LW-1:0] v;
    int t;
    v = '0;
    t = k - 2;
    if (k >= 2 && t <= 2*N-2)
      for (int l = 0; l < N; l++)
        if (t >= l && t - l < N)
          v[l*DW +: DW] = is_b ? mB[t-l][l] : mA[l][t-l];
    return v;
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("ld_ready",  {63'd0, ld_ready},  {63'd0, m_k == 0});
      chk("busy",      {63'd0, busy},      {63'd0, m_k >= 1 && m_k < DONE_K});
      chk("arr_clr",   {63'd0, arr_clr},   {63'd0, m_k == 1});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_k >= 2 && m_k < DONE_K});
      chk("done",      {63'd0, done},      {63'd0, m_k == DONE_K});
      chk("a_lanes",   {32'd0, a_lanes},   {32'd0, exp_lanes(0, m_k)});
      chk("b_lanes",   {32'd0, b_lanes},   {32'd0, exp_lanes(1, m_k)});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic mat, input int row, input logic [LW-1:0] data);
    ld_valid = 1'b1; ld_mat = mat; ld_row = RW'(row); ld_data = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_a_identity();
    logic [LW-1:0] d;
    for (int r = 0; r < N; r++) begin
      d = '0; d[r*DW +: DW] = 8'd1;
      load(1'b0, r, d);
    end
  endtask

  // B[r][c] = 4r+c+1, loaded in the orientation the build expects
  task automatic load_b_seq(input int nrows);
    logic [LW-1:0] d;
    for (int r = 0; r < nrows; r++) begin
      d = '0;
      for (int c = 0; c < N; c++)
`ifdef SYSTOLIC_FEEDER_BCOL_EN
        d[c*DW +: DW] = DW'(4*c + r + 1);
`else
        d[c*DW +: DW] = DW'(4*r + c + 1);
`endif
      load(1'b1, r, d);
    end
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
  endtask

  logic [LW-1:0] a_h [32];
  logic [LW-1:0] b_h [32];

  initial begin
    int cyc, n, acc, ndone;
    logic [LW-1:0] d;
    rst = 1'b1; ld_valid = 1'b0; ld_mat = 1'b0; ld_row = '0; ld_data = '0; go = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_a_lanes", {32'd0, a_lanes}, 64'd0);

    // go with 7 of 8 rows loaded is ignored
    load_a_identity();
    load_b_seq(N-1);
    go = 1'b1; tick(); go = 1'b0;
    chk("go_partial_clr", {63'd0, arr_clr}, 64'd0);
    load_b_seq(N);
    go = 1'b1; tick(); go = 1'b0;
    chk("go_full_clr", {63'd0, arr_clr}, 64'd1);
    tick();
    chk("t0_a", {32'd0, a_lanes}, 64'h00000001);
    chk("t0_b", {32'd0, b_lanes}, 64'h00000001);
    ld_valid = 1'b1; ld_mat = 1'b0; ld_row = RW'(3); ld_data = '1;
    chk("busy_ld_ready", {63'd0, ld_ready}, 64'd0);
    tick();
    ld_valid = 1'b0;
    tick(); tick();
    chk("t3_b", {32'd0, b_lanes}, 64'h04070A0D);
    chk("t3_a", {32'd0, a_lanes}, 64'h00000000);
    wait_done(5, cyc);
    chk("done_latency", 64'(cyc), 64'd13);
    tick();
    chk("fin_ld_ready", {63'd0, ld_ready}, 64'd1);
    go = 1'b1; tick(); go = 1'b0;
    chk("flags_cleared", {63'd0, arr_clr}, 64'd0);

    // reset while streaming t=3
    load_a_identity();
    load_b_seq(N);
    go = 1'b1; tick(); go = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_lanes", {a_lanes, b_lanes}, 64'd0);
    go = 1'b1; tick(); go = 1'b0;
    chk("rst_go_ignored", {63'd0, arr_clr}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 16; i++) begin tick(); if (done === 1'b1) ndone++; end
    chk("rst_no_done", 64'(ndone), 64'd0);

    // full product with a bench-side array: A[i][k]=i+k+1, B=1
    for (int r = 0; r < N; r++) begin
      d = '0;
      for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(r + k + 1);
      load(1'b0, r, d);
    end
    d = '0;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = 8'd1;
    for (int r = 0; r < N; r++) load(1'b1, r, d);
    go = 1'b1; tick(); go = 1'b0;
    cyc = 1; n = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick(); cyc++;
      if (out_valid === 1'b1) begin a_h[n] = a_lanes; b_h[n] = b_lanes; n++; end
    end
    chk("full_done_latency", 64'(cyc), 64'd13);
    chk("full_valid_len", 64'(n), 64'd11);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int c = 0; c < n + N; c++)
          if (c - j >= 0 && c - j < n && c - i >= 0 && c - i < n)
            acc += int'(a_h[c-j][i*DW +: DW]) * int'(b_h[c-i][j*DW +: DW]);
        chk($sformatf("c_%0d_%0d", i, j), 64'(acc), 64'(4*i + 10));
        if (i == 0 && j == 0) chk("c_r0", 64'(acc), 64'd10);
        if (i == N-1 && j == N-1) chk("c_r15", 64'(acc), 64'd22);
      end
    tick();

    // B with column c all c+1: column load, or transposed row load otherwise
    load_a_identity();
    for (int r = 0; r < N; r++) begin
      d = '0;
      for (int k = 0; k < N; k++)
`ifdef SYSTOLIC_FEEDER_BCOL_EN
        d[k*DW +: DW] = DW'(r + 1);
`else
        d[k*DW +: DW] = DW'(k + 1);
`endif
      load(1'b1, r, d);
    end
    go = 1'b1; tick(); go = 1'b0;
    tick(); tick(); tick(); tick();
    chk("bcol_t3_b", {32'd0, b_lanes}, 64'h04030201);
    wait_done(5, cyc);
    chk("bcol_done_latency", 64'(cyc), 64'd13);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
